// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and default link settings.
package uart_pkg;

    localparam int unsigned DEF_WIDTH        = 8;
    localparam int unsigned DEF_CLKS_PER_BIT = 434;
    localparam int unsigned STATE_W          = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_START  = 3'd1;
    localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
    localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: reloads on clear, counts down while enabled and strobes
// bit_end_c on the last cycle of every bit period.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic bit_end_c
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Reload on clear, count down and wrap at each bit boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= CNT_MAX;
        end else if (en) begin
            if (cnt_q == '0) begin
                cnt_q <= CNT_MAX;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    // Last cycle of the current bit period.
    assign bit_end_c = en && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_fpga.sv
// UART transmitter: accepts a word over valid/ready and sends
// start, WIDTH data bits LSB first, optional even parity, one stop bit.
module uart_tx_fpga
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH        = DEF_WIDTH,
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Data_In,
    input  logic             In_vld,
    output logic             In_rdy,
    output logic             Tx,
    output logic             Tx_busy,
    output logic             Tx_done
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    uart_state_e      state_q, state_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             tx_d, rdy_d, busy_d, done_d;
    logic             accept_c;
    logic             bit_end_c;

    assign accept_c = In_vld && (state_q == S_IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (accept_c),
        .en       (state_q != S_IDLE),
        .bit_end_c(bit_end_c)
    );

    // State, datapath and registered outputs; Tx falls back to idle-high on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bit_idx_q <= '0;
            hold_q    <= '0;
            Tx        <= 1'b1;
            In_rdy    <= 1'b1;
            Tx_busy   <= 1'b0;
            Tx_done   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            hold_q    <= hold_d;
            Tx        <= tx_d;
            In_rdy    <= rdy_d;
            Tx_busy   <= busy_d;
            Tx_done   <= done_d;
        end
    end

    // Next state and the line value for the cycle that follows.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        hold_d    = hold_q;
        tx_d      = Tx;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (accept_c) begin
                    state_d = S_START;
                    hold_d  = Data_In;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (bit_end_c) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                    tx_d      = hold_q[0];
                end
            end
            S_DATA: begin
                if (bit_end_c) begin
                    if (bit_idx_q == IDX_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                            tx_d    = ^hold_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        tx_d      = hold_q[bit_idx_d];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end_c) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end_c) begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        rdy_d  = (state_d == S_IDLE);
        busy_d = (state_d != S_IDLE);
    end

endmodule
